// File: rtl/spi_master_ctrl.sv
// SPI master: one DATA_W-bit word per accepted start, SCLK gated by a half-period tick.
// Define SPI_LSB_FIRST_EN for LSB-first shifting (tx and rx); default is MSB-first.
module spi_master_ctrl #(
   parameter int DIV_NUMBER = 6,
   parameter int DATA_W     = 8,
   parameter bit CPOL       = 1'b0,
   parameter bit CPHA       = 1'b0
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [DATA_W-1:0] tx_data,
   output logic              busy,
   output logic              done,
   output logic [DATA_W-1:0] rx_data,
   output logic              spi_sclk,
   output logic              spi_cs_n,
   output logic              spi_mosi,
   input  logic              spi_miso
);

   localparam int HALF   = DIV_NUMBER / 2;
   localparam int CNT_W  = (HALF > 1) ? $clog2(HALF) : 1;
   localparam int EDGES  = 2 * DATA_W;
   localparam int EDGE_W = $clog2(EDGES + 1);

   typedef enum logic [1:0] {IDLE, SETUP, XFER, HOLD} state_t;

   state_t              state_q, state_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [EDGE_W-1:0]   edge_q, edge_d, edge_nx;
   logic [DATA_W-1:0]   txsh_q, txsh_d;
   logic [DATA_W-1:0]   rxsh_q, rxsh_d;
   logic [DATA_W-1:0]   rx_q, rx_d;
   logic                busy_q, busy_d;
   logic                done_q, done_d;
   logic                sclk_q, sclk_d;
   logic                cs_n_q, cs_n_d;
   logic                mosi_q, mosi_d;
   logic                tick;

   assign tick    = (state_q != IDLE) && (cnt_q == CNT_W'(HALF - 1));
   assign edge_nx = edge_q + EDGE_W'(1);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         edge_q  <= '0;
         txsh_q  <= '0;
         rxsh_q  <= '0;
         rx_q    <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         sclk_q  <= CPOL;
         cs_n_q  <= 1'b1;
         mosi_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         edge_q  <= edge_d;
         txsh_q  <= txsh_d;
         rxsh_q  <= rxsh_d;
         rx_q    <= rx_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         sclk_q  <= sclk_d;
         cs_n_q  <= cs_n_d;
         mosi_q  <= mosi_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = (state_q == IDLE || tick) ? '0 : cnt_q + CNT_W'(1);
      edge_d  = edge_q;
      txsh_d  = txsh_q;
      rxsh_d  = rxsh_q;
      rx_d    = rx_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      sclk_d  = sclk_q;
      cs_n_d  = cs_n_q;
      mosi_d  = mosi_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               txsh_d  = tx_data;
               cs_n_d  = 1'b0;
               busy_d  = 1'b1;
               edge_d  = '0;
`ifdef SPI_LSB_FIRST_EN
               mosi_d  = tx_data[0];
`else
               mosi_d  = tx_data[DATA_W-1];
`endif
               state_d = SETUP;
            end
         end
         SETUP, XFER: begin
            if (tick) begin
               sclk_d  = ~sclk_q;
               edge_d  = edge_nx;
               state_d = (edge_nx == EDGE_W'(EDGES)) ? HOLD : XFER;
               // Sample edges have parity opposite to CPHA; the first and last edge never shift.
               if (edge_nx[0] != CPHA) begin
`ifdef SPI_LSB_FIRST_EN
                  rxsh_d = {spi_miso, rxsh_q[DATA_W-1:1]};
`else
                  rxsh_d = {rxsh_q[DATA_W-2:0], spi_miso};
`endif
               end else if (edge_nx != EDGE_W'(EDGES) && edge_nx != EDGE_W'(1)) begin
`ifdef SPI_LSB_FIRST_EN
                  txsh_d = txsh_q >> 1;
                  mosi_d = txsh_q[1];
`else
                  txsh_d = txsh_q << 1;
                  mosi_d = txsh_q[DATA_W-2];
`endif
               end
            end
         end
         HOLD: begin
            if (tick) begin
               cs_n_d  = 1'b1;
               busy_d  = 1'b0;
               done_d  = 1'b1;
               rx_d    = rxsh_q;
               mosi_d  = 1'b0;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign busy     = busy_q;
   assign done     = done_q;
   assign rx_data  = rx_q;
   assign spi_sclk = sclk_q;
   assign spi_cs_n = cs_n_q;
   assign spi_mosi = mosi_q;

endmodule

// File: tb/tb_spi_master_ctrl.sv
// Bench for spi_master_ctrl: default instance with loopback/slave model, plus a CPOL=1 CPHA=1 DIV=2 instance.
module tb_spi_master_ctrl;

   localparam int W   = 8;
   localparam int CS1 = (2 * W + 1) * 3;
   localparam int CS2 = (2 * W + 1) * 1;
`ifdef SPI_LSB_FIRST_EN
   localparam bit LSB = 1'b1;
`else
   localparam bit LSB = 1'b0;
`endif

   logic         clk, rst_n;
   logic         start, busy, done, sclk, cs_n, mosi, miso;
   logic [W-1:0] tx_data, rx_data;
   logic         loop_en, slave_bit;
   logic         start2, busy2, done2, sclk2, cs_n2, mosi2;
   logic [W-1:0] tx2, rx2;

   int errors = 0;
   int checks = 0;

   assign miso = loop_en ? mosi : slave_bit;

   spi_master_ctrl u_dut (
      .clk(clk), .rst_n(rst_n), .start(start), .tx_data(tx_data),
      .busy(busy), .done(done), .rx_data(rx_data),
      .spi_sclk(sclk), .spi_cs_n(cs_n), .spi_mosi(mosi), .spi_miso(miso)
   );

   spi_master_ctrl #(.DIV_NUMBER(2), .DATA_W(W), .CPOL(1'b1), .CPHA(1'b1)) u_dut2 (
      .clk(clk), .rst_n(rst_n), .start(start2), .tx_data(tx2),
      .busy(busy2), .done(done2), .rx_data(rx2),
      .spi_sclk(sclk2), .spi_cs_n(cs_n2), .spi_mosi(mosi2), .spi_miso(mosi2)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [W-1:0] tx;
      logic [W-1:0] sw;
      bit           lp;
      logic [W-1:0] exp_rx;
   } vec_t;
   vec_t vecs[5];

   // i-th bit on the wire for a word, in the build's shift order
   function automatic logic bit_at(input logic [W-1:0] w, input int i);
      return LSB ? w[i] : w[W-1-i];
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic xfer1(input logic [W-1:0] tx, input logic [W-1:0] sw, input bit lp,
                        input logic [W-1:0] exp_rx);
      int cs_cnt, rises, lead, idx, budget;
      logic prev;
      logic [W-1:0] cap;
      loop_en = lp;
      @(negedge clk);
      start = 1'b1; tx_data = tx; slave_bit = bit_at(sw, 0);
      @(negedge clk);
      start = 1'b0; tx_data = W'($urandom);
      check("start_busy", busy, 1);
      check("start_cs_n", cs_n, 0);
      check("start_mosi", mosi, bit_at(tx, 0));
      cs_cnt = 0; rises = 0; lead = 0; idx = 0; budget = 200; prev = sclk; cap = '0;
      while (!done && budget > 0) begin
         if (!cs_n) cs_cnt++;
         if (sclk && !prev) begin
            rises++;
            if (lead < W) cap[LSB ? lead : W-1-lead] = mosi;
            lead++;
         end else if (!sclk && prev) begin
            idx++;
            if (idx < W) slave_bit = bit_at(sw, idx);
         end
         prev  = sclk;
         start = ($urandom_range(0, 3) == 0);
         tx_data = W'($urandom);
         @(negedge clk);
         budget--;
      end
      start = 1'b0;
      if (budget == 0) check("xfer_timeout", 0, 1);
      check("rx_data", rx_data, exp_rx);
      check("mosi_word", cap, tx);
      check("cs_low_cycles", cs_cnt, CS1);
      check("sclk_rises", rises, W);
      check("done_busy", busy, 0);
      check("done_cs_n", cs_n, 1);
      check("done_mosi", mosi, 0);
      @(negedge clk);
      check("done_pulse", done, 0);
      check("rx_hold", rx_data, exp_rx);
   endtask

   task automatic xfer2(input logic [W-1:0] tx);
      int cs_cnt, budget;
      @(negedge clk);
      check("d2_idle_sclk", sclk2, 1);
      start2 = 1'b1; tx2 = tx;
      @(negedge clk);
      start2 = 1'b0; tx2 = ~tx;
      cs_cnt = 0; budget = 100;
      while (!done2 && budget > 0) begin
         if (!cs_n2) cs_cnt++;
         @(negedge clk);
         budget--;
      end
      if (budget == 0) check("d2_timeout", 0, 1);
      check("d2_rx", rx2, tx);
      check("d2_cs_low_cycles", cs_cnt, CS2);
      check("d2_end_sclk", sclk2, 1);
      check("d2_busy", busy2, 0);
   endtask

   initial begin
      logic [W-1:0] words[3];
      logic [W-1:0] rtx, rsw;
      bit           rlp;
      int           edges, budget;
      logic         prev, seen;

      clk = 1'b0; rst_n = 1'b0; start = 1'b0; tx_data = '0;
      loop_en = 1'b1; slave_bit = 1'b0; start2 = 1'b0; tx2 = '0;

      vecs[0] = '{8'hA5, 8'h00, 1'b1, 8'hA5};
      vecs[1] = '{8'hFF, 8'h3C, 1'b0, 8'h3C};
      vecs[2] = '{8'h01, 8'h00, 1'b1, 8'h01};
      vecs[3] = '{8'h00, 8'hC7, 1'b0, 8'hC7};
      vecs[4] = '{8'h5A, 8'hFF, 1'b0, 8'hFF};

      repeat (3) @(negedge clk);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_rx", rx_data, 0);
      check("rst_sclk", sclk, 0);
      check("rst_cs_n", cs_n, 1);
      check("rst_mosi", mosi, 0);
      check("rst_sclk2", sclk2, 1);
      rst_n = 1'b1;

      for (int i = 0; i < 5; i++) xfer1(vecs[i].tx, vecs[i].sw, vecs[i].lp, vecs[i].exp_rx);

      for (int i = 0; i < 12; i++) begin
         rtx = W'($urandom);
         rsw = W'($urandom);
         rlp = bit'($urandom_range(0, 1));
         xfer1(rtx, rsw, rlp, rlp ? rtx : rsw);
      end

      // back-to-back with start held high
      words[0] = 8'h12; words[1] = 8'h34; words[2] = 8'h56;
      loop_en = 1'b1;
      @(negedge clk);
      start = 1'b1; tx_data = words[0];
      for (int k = 0; k < 3; k++) begin
         budget = 200;
         @(negedge clk);
         while (!done && budget > 0) begin
            @(negedge clk);
            budget--;
         end
         if (budget == 0) check("b2b_timeout", 0, 1);
         check("b2b_rx", rx_data, words[k]);
         check("b2b_done_cs_n", cs_n, 1);
         if (k < 2) tx_data = words[k+1];
         else start = 1'b0;
         @(negedge clk);
         check("b2b_next_cs_n", cs_n, (k < 2) ? 0 : 1);
         check("b2b_done_pulse", done, 0);
      end

      // reset after the 7th SCLK edge
      @(negedge clk);
      start = 1'b1; tx_data = 8'hC3;
      @(negedge clk);
      start = 1'b0; edges = 0; prev = sclk; budget = 100;
      while (edges < 7 && budget > 0) begin
         @(negedge clk);
         budget--;
         if (sclk !== prev) edges++;
         prev = sclk;
      end
      if (budget == 0) check("rst_wait_timeout", 0, 1);
      check("pre_rst_sclk", sclk, 1);
      rst_n = 1'b0;
      #1;
      check("abort_cs_n", cs_n, 1);
      check("abort_sclk", sclk, 0);
      check("abort_busy", busy, 0);
      check("abort_rx", rx_data, 0);
      check("abort_done", done, 0);
      @(negedge clk);
      rst_n = 1'b1;
      seen = 1'b0;
      repeat (60) begin
         @(negedge clk);
         if (done) seen = 1'b1;
      end
      check("abort_no_done", seen, 0);
      xfer1(8'h5A, 8'h00, 1'b1, 8'h5A);

      xfer2(8'h81);
      for (int i = 0; i < 3; i++) xfer2(W'($urandom));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
